// File: rtl/sort_pkg.sv
// Shared constants for the sorting-network accelerator datapath.
package sort_pkg;
  localparam int DATA_W      = 32;
  localparam int FRAME_LEN   = 10;
  localparam int FRAME_CNT_W = 16;
  localparam int FIFO_DEPTH  = 16;
endpackage

// File: rtl/sort_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into an empty FIFO shows on rd_data one cycle later, never in the same cycle.
module sort_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sort_stream_framer.sv
// Buffers the sorter result stream, regenerates tlast every FRAME_LEN words and
// flags any descending pair seen inside a frame.
module sort_stream_framer #(
  parameter  int DATA_W    = sort_pkg::DATA_W,
  parameter  int FRAME_LEN = sort_pkg::FRAME_LEN,
  parameter  int DEPTH     = sort_pkg::FIFO_DEPTH,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                             axis_clk,
  input  logic                             rst_n,
  input  logic                             s_tvalid,
  input  logic [DATA_W-1:0]                s_tdata,
  output logic                             s_tready,
  output logic                             m_tvalid,
  output logic [DATA_W-1:0]                m_tdata,
  output logic                             m_tlast,
  input  logic                             m_tready,
  output logic                             frame_done,
  output logic [sort_pkg::FRAME_CNT_W-1:0] frame_cnt,
  output logic                             order_err,
  input  logic                             err_clr,
  output logic [LW-1:0]                    level
);

  localparam int            IW       = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              descending;
  logic [IW-1:0]     in_idx;
  logic [IW-1:0]     out_idx;
  logic [DATA_W-1:0] prev;

  // Handshake decodes come only from FIFO state, so there is no input-to-output comb path.
  assign s_tready   = !full;
  assign m_tvalid   = !empty;
  assign push       = s_tvalid && s_tready;
  assign pop        = m_tvalid && m_tready;
  assign m_tlast    = m_tvalid && (out_idx == LAST_IDX);
  assign descending = push && (in_idx != '0) && (s_tdata < prev);

  sort_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (axis_clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (s_tdata),
    .pop     (pop),
    .rd_data (m_tdata),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge axis_clk) begin
    if (!rst_n) begin
      out_idx    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && m_tlast;
      if (pop) begin
        if (m_tlast) begin
          out_idx   <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          out_idx <= out_idx + 1'b1;
        end
      end
    end
  end

  // Word 0 of each frame is exempt from the order check; a fresh error beats err_clr.
  always_ff @(posedge axis_clk) begin
    if (!rst_n) begin
      in_idx    <= '0;
      prev      <= '0;
      order_err <= 1'b0;
    end else begin
      if (push) begin
        prev   <= s_tdata;
        in_idx <= (in_idx == LAST_IDX) ? '0 : in_idx + 1'b1;
      end
      if (descending) begin
        order_err <= 1'b1;
      end else if (err_clr) begin
        order_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort_stream_framer.sv
// Self-checking bench for sort_stream_framer: directed scenarios plus a randomized
// run scored against a queue-based model of the stream.
module tb_sort_stream_framer;

  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 10;
  localparam int DEPTH     = 16;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic              axis_clk = 1'b0;
  logic              rst_n    = 1'b0;
  logic              s_tvalid = 1'b0;
  logic [DATA_W-1:0] s_tdata  = '0;
  logic              s_tready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready = 1'b0;
  logic              frame_done;
  logic [15:0]       frame_cnt;
  logic              order_err;
  logic              err_clr  = 1'b0;
  logic [LW-1:0]     level;

  always #5 axis_clk = ~axis_clk;

  sort_stream_framer dut (
    .axis_clk   (axis_clk),
    .rst_n      (rst_n),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .order_err  (order_err),
    .err_clr    (err_clr),
    .level      (level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffered words plus running totals since the last reset.
  logic [DATA_W-1:0] mq [$];
  int                push_total = 0;
  int                pop_total  = 0;
  logic [DATA_W-1:0] last_word  = '0;
  logic              m_err      = 1'b0;
  logic              m_done     = 1'b0;

  // Values seen just before the clock edge of the last cycle, with model expectations.
  logic              obs_push, obs_pop, obs_ready, obs_valid, obs_last;
  logic [DATA_W-1:0] obs_data;
  logic [LW-1:0]     obs_level;
  logic              exp_ready, exp_valid, exp_last;
  logic [DATA_W-1:0] exp_data;
  logic [LW-1:0]     exp_level;

  function automatic logic [15:0] model_frames();
    return 16'((pop_total / FRAME_LEN) % 65536);
  endfunction

  // Drives one cycle of inputs, records pre-edge outputs, then advances the model.
  task automatic run_cycle(input logic sv, input logic [DATA_W-1:0] sd,
                           input logic mr, input logic ec);
    logic new_err;
    s_tvalid  = sv;
    s_tdata   = sd;
    m_tready  = mr;
    err_clr   = ec;
    exp_ready = (mq.size() < DEPTH);
    exp_valid = (mq.size() != 0);
    exp_level = LW'(mq.size());
    exp_data  = exp_valid ? mq[0] : '0;
    exp_last  = exp_valid && ((pop_total % FRAME_LEN) == FRAME_LEN - 1);
    obs_push  = rst_n && sv && exp_ready;
    obs_pop   = rst_n && mr && exp_valid;
    obs_ready = s_tready;
    obs_valid = m_tvalid;
    obs_last  = m_tlast;
    obs_data  = m_tdata;
    obs_level = level;
    @(posedge axis_clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      push_total = 0;
      pop_total  = 0;
      last_word  = '0;
      m_err      = 1'b0;
      m_done     = 1'b0;
    end else begin
      m_done  = obs_pop && exp_last;
      new_err = obs_push && ((push_total % FRAME_LEN) != 0) && (sd < last_word);
      if (obs_pop) begin
        void'(mq.pop_front());
        pop_total++;
      end
      if (obs_push) begin
        mq.push_back(sd);
        push_total++;
        last_word = sd;
      end
      if (new_err) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_tready got %0b want 1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tvalid got %0b want 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tlast got %0b want 0", m_tlast); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %0b want 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_order_err got %0b want 0", order_err); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
  endtask

  task automatic test_single_frame();
    int sent, got, dones, cyc;
    sent = 0; got = 0; dones = 0; cyc = 0;
    apply_reset();
    while (got < 10 && cyc < 60) begin
      run_cycle(sent < 10, 32'(sent + 1), 1'b1, 1'b0);
      if (cyc == 0) begin
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass got %0b want 0", obs_valid); end
      end
      if (obs_push) sent++;
      if (obs_pop) begin
        checks++; if (obs_data !== 32'(got + 1)) begin errors++; $display("[TB] FAIL single_data got %0d want %0d", obs_data, got + 1); end
        checks++; if (obs_last !== (got == 9)) begin errors++; $display("[TB] FAIL single_tlast beat %0d got %0b want %0b", got, obs_last, got == 9); end
        got++;
      end
      if (frame_done) dones++;
      cyc++;
    end
    checks++; if (got != 10) begin errors++; $display("[TB] FAIL single_timeout got %0d beats want 10", got); end
    run_cycle(1'b0, '0, 1'b1, 1'b0);
    if (frame_done) dones++;
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL single_frame_done got %0d pulses want 1", dones); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL single_frame_cnt got %0d want 1", frame_cnt); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL single_order_err got %0b want 0", order_err); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got %0b want 0", m_tvalid); end
  endtask

  task automatic test_backpressure();
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      run_cycle(1'b1, 32'(sent + 1), 1'b0, 1'b0);
      checks++; if (obs_ready !== (sent < DEPTH)) begin errors++; $display("[TB] FAIL bp_s_tready cycle %0d got %0b want %0b", c, obs_ready, sent < DEPTH); end
      if (obs_push) sent++;
      checks++; if (m_tdata !== 32'd1) begin errors++; $display("[TB] FAIL bp_hold_data cycle %0d got %0d want 1", c, m_tdata); end
    end
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL bp_level got %0d want %0d", level, DEPTH); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got %0b want 0", s_tready); end
    while (got < 20 && cyc < 100) begin
      run_cycle(sent < 20, 32'(sent + 1), 1'b1, 1'b0);
      checks++; if (obs_level !== exp_level) begin errors++; $display("[TB] FAIL bp_level_track got %0d want %0d", obs_level, exp_level); end
      if (obs_push) sent++;
      if (obs_pop) begin
        checks++; if (obs_data !== 32'(got + 1)) begin errors++; $display("[TB] FAIL bp_data got %0d want %0d", obs_data, got + 1); end
        checks++; if (obs_last !== (got == 9 || got == 19)) begin errors++; $display("[TB] FAIL bp_tlast beat %0d got %0b", got, obs_last); end
        got++;
      end
      cyc++;
    end
    checks++; if (got != 20) begin errors++; $display("[TB] FAIL bp_timeout got %0d beats want 20", got); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL bp_frame_cnt got %0d want 2", frame_cnt); end
  endtask

  task automatic test_order_err();
    logic [DATA_W-1:0] vals [10];
    vals = '{5, 7, 7, 3, 9, 10, 11, 12, 13, 14};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, vals[i], 1'b1, 1'b0);
      checks++; if (order_err !== (i >= 3)) begin errors++; $display("[TB] FAIL order_set word %0d got %0b want %0b", i, order_err, i >= 3); end
    end
    run_cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL order_clear got %0b want 0", order_err); end
    run_cycle(1'b1, 32'd20, 1'b1, 1'b0);
    run_cycle(1'b1, 32'd10, 1'b1, 1'b1);
    checks++; if (order_err !== 1'b1) begin errors++; $display("[TB] FAIL order_err_wins got %0b want 1", order_err); end
    run_cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL order_clear2 got %0b want 0", order_err); end
  endtask

  task automatic test_frame_boundary();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b1, (i < 10) ? 32'(91 + i) : 32'(i - 9), 1'b1, 1'b0);
    end
    checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL boundary_order_err got %0b want 0", order_err); end
  endtask

  task automatic test_mid_reset();
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 32'(i + 1), 1'b0, 1'b0);
    checks++; if (level !== LW'(4)) begin errors++; $display("[TB] FAIL midrst_fill got %0d want 4", level); end
    rst_n = 1'b0;
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_m_tvalid got %0b want 0", m_tvalid); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL midrst_level got %0d want 0", level); end
    while (got < 10 && cyc < 60) begin
      run_cycle(sent < 10, 32'(50 + sent), 1'b1, 1'b0);
      if (obs_push) sent++;
      if (obs_pop) begin
        checks++; if (obs_data !== 32'(50 + got)) begin errors++; $display("[TB] FAIL midrst_data got %0d want %0d", obs_data, 50 + got); end
        checks++; if (obs_last !== (got == 9)) begin errors++; $display("[TB] FAIL midrst_tlast beat %0d got %0b", got, obs_last); end
        got++;
      end
      cyc++;
    end
    checks++; if (got != 10) begin errors++; $display("[TB] FAIL midrst_timeout got %0d beats want 10", got); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL midrst_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_random();
    int                cyc;
    logic              sv;
    logic [DATA_W-1:0] nxt;
    cyc = 0;
    nxt = 32'($urandom_range(0, 255));
    apply_reset();
    while (pop_total < 10000 && cyc < 60000) begin
      sv = ($urandom_range(0, 3) != 0) && (push_total < 10000);
      run_cycle(sv, nxt, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      if (obs_push) nxt = 32'($urandom_range(0, 255));
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_s_tready cyc %0d got %0b want %0b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_m_tvalid cyc %0d got %0b want %0b", cyc, obs_valid, exp_valid); end
      checks++; if (obs_level !== exp_level) begin errors++; $display("[TB] FAIL rnd_level cyc %0d got %0d want %0d", cyc, obs_level, exp_level); end
      if (obs_pop) begin
        checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL rnd_data cyc %0d got %0d want %0d", cyc, obs_data, exp_data); end
        checks++; if (obs_last !== exp_last) begin errors++; $display("[TB] FAIL rnd_tlast cyc %0d got %0b want %0b", cyc, obs_last, exp_last); end
      end
      checks++; if (frame_done !== m_done) begin errors++; $display("[TB] FAIL rnd_frame_done cyc %0d got %0b want %0b", cyc, frame_done, m_done); end
      checks++; if (order_err !== m_err) begin errors++; $display("[TB] FAIL rnd_order_err cyc %0d got %0b want %0b", cyc, order_err, m_err); end
      checks++; if (frame_cnt !== model_frames()) begin errors++; $display("[TB] FAIL rnd_frame_cnt cyc %0d got %0d want %0d", cyc, frame_cnt, model_frames()); end
      cyc++;
    end
    checks++; if (pop_total != 10000) begin errors++; $display("[TB] FAIL rnd_timeout got %0d pops want 10000", pop_total); end
    checks++; if (frame_cnt !== 16'd1000) begin errors++; $display("[TB] FAIL rnd_total_frames got %0d want 1000", frame_cnt); end
  endtask

  initial begin
    $display("[TB] starting sort_stream_framer bench");
    test_reset();
    test_single_frame();
    test_backpressure();
    test_order_err();
    test_frame_boundary();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
